muldiv_ctrl: RTL and testbench

//   Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and owner of the HI/LO registers.

---
 rtl/muldiv_ctrl_pkg.sv | 29 ++
 rtl/muldiv_ctrl_if.sv | 33 +++
 rtl/muldiv_ctrl_step.sv | 49 ++++
 rtl/muldiv_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared encodings for the multiply/divide sequencer:
//     - MD_* operation encodings (MULT, MULTU, DIV, DIVU)
//     - FSM state encodings (MD_IDLE, MD_CALC, MD_FIX)
//     - small decode helpers for the op field
package muldiv_ctrl_pkg;

  // Operation encodings
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states
  localparam logic [1:0] MD_IDLE  = 2'b00;
  localparam logic [1:0] MD_CALC  = 2'b01;
  localparam logic [1:0] MD_FIX   = 2'b10;

  // DIV/DIVU have op[1] set
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT/DIV (op[0] clear) treat operands as two's complement
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Issue/result bundle between the EX stage and the mul/div sequencer.
//   master : EX-stage side (drives start/op/operands/flush/MT writes)
//   slave  : muldiv_ctrl (drives busy/done and the HI/LO registers)
//   Signals: start, op[1:0], rs_val, rt_val, flush, mthi, mtlo,
//            hi_wdata, lo_wdata -> slave ; busy, done, hi, lo -> master
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush, mthi, mtlo, hi_wdata, lo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mthi, mtlo, hi_wdata, lo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// muldiv_ctrl_step
//   One combinational iteration of the unsigned sequencer datapath.
//   Multiply: {a,b} = {acc, multiplier}; conditionally add m (multiplicand)
//             to acc when b[0] is set, then shift the WIDTH*2+1 value right.
//   Divide:   {a,b} = {remainder, quotient/dividend}; shift left by one,
//             trial-subtract m (divisor), keep the difference when it fits.
//   Ports: is_div_i, a_i, b_i, m_i -> a_o, b_o
module muldiv_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           fits_s;

  // Shift-add multiply step or restoring divide step
  always_comb begin
    if (b_i[0]) begin
      sum_s = {1'b0, a_i} + {1'b0, m_i};
    end else begin
      sum_s = {1'b0, a_i};
    end
    shifted_s = {a_i, b_i[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, m_i};
    fits_s    = (shifted_s >= {1'b0, m_i});
    if (is_div_i) begin
      if (fits_s) begin
        a_o = diff_s[WIDTH-1:0];
        b_o = {b_i[WIDTH-2:0], 1'b1};
      end else begin
        a_o = shifted_s[WIDTH-1:0];
        b_o = {b_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // carry out of the add shifts down into acc, acc LSB into the multiplier
      a_o = sum_s[WIDTH:1];
      b_o = {sum_s[0], b_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of HI/LO.
//   IDLE -start-> CALC (WIDTH cycles) -> FIX (sign fix-up, HI/LO write) -> IDLE.
//   Signed ops iterate on magnitudes; FIX restores the signs.
//   Ports: clk, rst_n (async active-low), md (muldiv_ctrl_if.slave):
//     start/op/rs_val/rt_val issue, flush kill, mthi/mtlo/hi_wdata/lo_wdata
//     idle-only HI/LO writes, busy/done status, hi/lo results.
//   Option: define MULDIV_FAST_ZERO_EN to skip CALC for zero-result ops
//     (MULT* with a zero operand, DIV* with zero dividend and nonzero divisor).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  md
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;       // acc / remainder
  logic [WIDTH-1:0]   b_q, b_d;       // multiplier / quotient
  logic [WIDTH-1:0]   m_q, m_d;       // multiplicand / divisor
  logic               div_q, div_d;
  logic               neg_q, neg_d;   // negate product or quotient
  logic               rneg_q, rneg_d; // negate remainder
  logic               dz_q, dz_d;     // divide by zero
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_div_s;
  logic               sa_s;
  logic               sb_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic               fast_zero_s;
  logic [WIDTH-1:0]   step_a_s;
  logic [WIDTH-1:0]   step_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign op_div_s = md_is_div(md.op);
  assign sa_s     = md_is_signed(md.op) & md.rs_val[WIDTH-1];
  assign sb_s     = md_is_signed(md.op) & md.rt_val[WIDTH-1];

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero_s = op_div_s
                     ? ((md.rs_val == {WIDTH{1'b0}}) && (md.rt_val != {WIDTH{1'b0}}))
                     : ((md.rs_val == {WIDTH{1'b0}}) || (md.rt_val == {WIDTH{1'b0}}));
`else
  assign fast_zero_s = 1'b0;
`endif

  // Operand magnitudes (the most negative value maps onto itself, unsigned-correct)
  always_comb begin
    if (sa_s) begin
      mag_a_s = {WIDTH{1'b0}} - md.rs_val;
    end else begin
      mag_a_s = md.rs_val;
    end
    if (sb_s) begin
      mag_b_s = {WIDTH{1'b0}} - md.rt_val;
    end else begin
      mag_b_s = md.rt_val;
    end
  end

  muldiv_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (div_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .m_i      (m_q),
    .a_o      (step_a_s),
    .b_o      (step_b_s)
  );

  // Sign fix-up of the finished magnitudes
  always_comb begin
    prod_s = {a_q, b_q};
    if (neg_q) begin
      prod_fix_s = {(2*WIDTH){1'b0}} - prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    if (dz_q) begin
      quo_fix_s = {WIDTH{1'b1}};
    end else if (neg_q) begin
      quo_fix_s = {WIDTH{1'b0}} - b_q;
    end else begin
      quo_fix_s = b_q;
    end
    // with a zero divisor the remainder iterates to |rs|; restoring its sign gives raw rs
    if (rneg_q) begin
      rem_fix_s = {WIDTH{1'b0}} - a_q;
    end else begin
      rem_fix_s = a_q;
    end
  end

  // Next-state: FSM, counter, datapath loads/steps and HI/LO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          // start beats a same-cycle MT write and a same-cycle flush
          div_d  = op_div_s;
          neg_d  = sa_s ^ sb_s;
          rneg_d = op_div_s & sa_s;
          dz_d   = op_div_s & (md.rt_val == {WIDTH{1'b0}});
          a_d    = {WIDTH{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          busy_d = 1'b1;
          if (op_div_s) begin
            b_d = mag_a_s;
            m_d = mag_b_s;
          end else begin
            b_d = mag_b_s;
            m_d = mag_a_s;
          end
          if (fast_zero_s) begin
            // zeroed magnitudes make FIX produce HI=LO=0
            b_d     = {WIDTH{1'b0}};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            dz_d    = 1'b0;
            state_d = MD_FIX;
          end else begin
            state_d = MD_CALC;
          end
        end else begin
          busy_d = 1'b0;
          if (md.mthi) begin
            hi_d = md.hi_wdata;
          end else begin
            hi_d = hi_q;
          end
          if (md.mtlo) begin
            lo_d = md.lo_wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      MD_CALC: begin
        if (md.flush) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          a_d = step_a_s;
          b_d = step_b_s;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MD_FIX;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        if (md.flush) begin
          hi_d = hi_q;
          lo_d = lo_q;
        end else begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end else begin
            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Directed vectors with hand-computed HI/LO results and latencies for
//   muldiv_ctrl (WIDTH=32). Cycle 0 is the cycle in which start is driven;
//   outputs are sampled 1 time unit after each rising edge.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_ZERO_EN
  localparam int FZ_LAT = 2;
`else
  localparam int FZ_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat;
  logic flag;

  muldiv_ctrl_if #(.WIDTH(W)) md_if ();

  muldiv_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done, counting cycles from lat0; gives up after 100 cycles
  task automatic wait_done(input int lat0, output int lat_o);
    lat_o = lat0;
    while (md_if.done !== 1'b1 && lat_o < 100) begin
      tick();
      lat_o++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat_o);
    md_if.op     = op;
    md_if.rs_val = a;
    md_if.rt_val = b;
    md_if.start  = 1'b1;
    tick();
    md_if.start  = 1'b0;
    wait_done(1, lat_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    md_if.start    = 1'b0;
    md_if.op       = MD_MULT;
    md_if.rs_val   = 32'h0;
    md_if.rt_val   = 32'h0;
    md_if.flush    = 1'b0;
    md_if.mthi     = 1'b0;
    md_if.mtlo     = 1'b0;
    md_if.hi_wdata = 32'h0;
    md_if.lo_wdata = 32'h0;
    #1;
    check_eq("reset_busy", 64'(md_if.busy), 64'h0);
    check_eq("reset_done", 64'(md_if.done), 64'h0);
    check_eq("reset_hi",   64'(md_if.hi),   64'h0);
    check_eq("reset_lo",   64'(md_if.lo),   64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MULT -3*5 with per-cycle busy/done tracking
    md_if.op = MD_MULT; md_if.rs_val = 32'hFFFF_FFFD; md_if.rt_val = 32'd5;
    md_if.start = 1'b1;
    tick();
    md_if.start = 1'b0;
    flag = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (md_if.busy !== 1'b1 || md_if.done !== 1'b0) flag = 1'b0;
      if (c < 33) tick();
    end
    check_eq("mult_busy_1_33", 64'(flag), 64'h1);
    tick();
    check_eq("mult_done_c34", 64'(md_if.done), 64'h1);
    check_eq("mult_busy_c34", 64'(md_if.busy), 64'h0);
    check_eq("mult_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Back-to-back ops, each issued in the previous op's done cycle
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check_eq("multu_lat", 64'(lat), 64'd34);
    check_eq("multu_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check_eq("div_neg_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MD_DIVU, 32'd100, 32'd7, lat);
    check_eq("divu_lat", 64'(lat), 64'd34);
    check_eq("divu_hilo", {md_if.hi, md_if.lo}, {32'd2, 32'd14});
    do_op(MD_DIVU, 32'd7, 32'd0, lat);
    check_eq("divu_zero_hilo", {md_if.hi, md_if.lo}, {32'd7, 32'hFFFF_FFFF});
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, lat);
    check_eq("div_zero_neg_hilo", {md_if.hi, md_if.lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check_eq("div_ovf_hilo", {md_if.hi, md_if.lo}, {32'h0, 32'h8000_0000});
    tick();

    // MTHI and MTLO together
    md_if.mthi = 1'b1; md_if.mtlo = 1'b1;
    md_if.hi_wdata = 32'hAAAA_5555; md_if.lo_wdata = 32'h0F0F_0F0F;
    tick();
    md_if.mthi = 1'b0; md_if.mtlo = 1'b0;
    check_eq("mt_both", {md_if.hi, md_if.lo}, 64'hAAAA_5555_0F0F_0F0F);

    // start with MTHI in IDLE: start wins
    md_if.op = MD_MULTU; md_if.rs_val = 32'd3; md_if.rt_val = 32'd4;
    md_if.mthi = 1'b1; md_if.hi_wdata = 32'h0000_0BAD; md_if.start = 1'b1;
    tick();
    md_if.mthi = 1'b0; md_if.start = 1'b0;
    check_eq("start_beats_mthi", 64'(md_if.hi), 64'hAAAA_5555);
    wait_done(1, lat);
    check_eq("multu_3x4_hilo", {md_if.hi, md_if.lo}, {32'd0, 32'd12});

    // flush and start in the same IDLE cycle: start accepted
    md_if.op = MD_MULTU; md_if.rs_val = 32'd5; md_if.rt_val = 32'd5;
    md_if.flush = 1'b1; md_if.start = 1'b1;
    tick();
    md_if.flush = 1'b0; md_if.start = 1'b0;
    check_eq("flush_start_busy", 64'(md_if.busy), 64'h1);
    wait_done(1, lat);
    check_eq("flush_start_lat", 64'(lat), 64'd34);
    check_eq("flush_start_lo", 64'(md_if.lo), 64'd25);
    tick();

    // MTHI 0x1234, then MULT 2*3 killed in cycle 10
    md_if.mthi = 1'b1; md_if.hi_wdata = 32'h0000_1234;
    tick();
    md_if.mthi = 1'b0;
    check_eq("mthi_write", 64'(md_if.hi), 64'h1234);
    md_if.op = MD_MULT; md_if.rs_val = 32'd2; md_if.rt_val = 32'd3; md_if.start = 1'b1;
    tick();
    md_if.start = 1'b0;
    repeat (9) tick();
    check_eq("flush_busy_c10", 64'(md_if.busy), 64'h1);
    md_if.flush = 1'b1;
    tick();
    md_if.flush = 1'b0;
    check_eq("flush_busy_c11", 64'(md_if.busy), 64'h0);
    check_eq("flush_hilo_kept", {md_if.hi, md_if.lo}, {32'h1234, 32'd25});
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (md_if.done === 1'b1) flag = 1'b1;
      tick();
    end
    check_eq("flush_no_done", 64'(flag), 64'h0);

    // MULT 7*6 with a second start and an MTLO in cycle 5
    md_if.op = MD_MULT; md_if.rs_val = 32'd7; md_if.rt_val = 32'd6; md_if.start = 1'b1;
    tick();
    md_if.start = 1'b0;
    repeat (4) tick();
    md_if.op = MD_DIVU; md_if.rs_val = 32'd9; md_if.rt_val = 32'd3; md_if.start = 1'b1;
    md_if.mtlo = 1'b1; md_if.lo_wdata = 32'h0000_DEAD;
    tick();
    md_if.start = 1'b0; md_if.mtlo = 1'b0;
    check_eq("mtlo_busy_dropped", 64'(md_if.lo), 64'd25);
    wait_done(6, lat);
    check_eq("restart_ignored_lat", 64'(lat), 64'd34);
    check_eq("restart_ignored_hilo", {md_if.hi, md_if.lo}, {32'd0, 32'd42});

    // Reset in cycle 20 of a DIV takes effect between clock edges
    md_if.op = MD_DIV; md_if.rs_val = 32'd100; md_if.rt_val = 32'd3; md_if.start = 1'b1;
    tick();
    md_if.start = 1'b0;
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(md_if.busy), 64'h0);
    check_eq("rst_mid_hilo", {md_if.hi, md_if.lo}, 64'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("rst_after_done", 64'(md_if.done), 64'h0);
    check_eq("rst_after_busy", 64'(md_if.busy), 64'h0);

    // MULT 0*0x55: zero result, latency depends on the fast-zero option
    md_if.mthi = 1'b1; md_if.mtlo = 1'b1;
    md_if.hi_wdata = 32'h11; md_if.lo_wdata = 32'h22;
    tick();
    md_if.mthi = 1'b0; md_if.mtlo = 1'b0;
    do_op(MD_MULT, 32'd0, 32'h55, lat);
    check_eq("zero_mult_lat", 64'(lat), 64'(FZ_LAT));
    check_eq("zero_mult_hilo", {md_if.hi, md_if.lo}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
